id_ex_stage: RTL

- Pipeline register between instruction decode (ID) and execute (EX) of the 5-stage core.
- Captures decoded operands each cycle and applies the rA/rB forward selects produced by the forwarding logic, choosing the EX result over register-file data.
- Detects load-use hazards, inserts one bubble, and supports downstream hold and branch flush.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/operand_resolve.sv | 32 +++
 rtl/id_ex_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core widths, register-zero constant and opcodes
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 6;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam logic [OP_W-1:0] OP_ALU  = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
    localparam logic [OP_W-1:0] OP_LD   = 6'h23;
    localparam logic [OP_W-1:0] OP_ST   = 6'h2B;

    localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB  = 6'h22;

endpackage

// File: rtl/operand_resolve.sv
// rtl/operand_resolve.sv - EX/MEM/register-file priority select for one source operand
module operand_resolve #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] srcAddress,
    input  logic [DATA_W-1:0] idData,
    input  logic              forward,
    input  logic              exFwdOk,
    input  logic [DATA_W-1:0] exResult,
    input  logic              memWriting,
    input  logic [ADDR_W-1:0] memRdAddress,
    input  logic [DATA_W-1:0] memResult,
    output logic [DATA_W-1:0] data
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(cpu_pkg::REG_ZERO);

    logic notZero;
    assign notZero = (srcAddress != ZERO);

    // Register zero always reads the register-file value, whatever the bypasses claim.
    always_comb begin
        data = idData;
        if (forward && exFwdOk && notZero) begin
            data = exResult;
        end else if (memWriting && (memRdAddress == srcAddress) && notZero) begin
            data = memResult;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use bubble, hold and flush
module id_ex_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int OP_W   = cpu_pkg::OP_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rA_address,
    input  logic [ADDR_W-1:0] id_rB_address,
    input  logic [ADDR_W-1:0] id_rD_address,
    input  logic [DATA_W-1:0] id_rA_data,
    input  logic [DATA_W-1:0] id_rB_data,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [OP_W-1:0]   id_func,
    input  logic              id_is_load,
    input  logic              id_reg_write,
    input  logic              forward_rA,
    input  logic              forward_rB,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_rD_address,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_rA_address,
    output logic [ADDR_W-1:0] ex_rB_address,
    output logic [ADDR_W-1:0] ex_rD_address,
    output logic [DATA_W-1:0] ex_rA_data,
    output logic [DATA_W-1:0] ex_rB_data,
    output logic [OP_W-1:0]   ex_opcode,
    output logic [OP_W-1:0]   ex_func,
    output logic              ex_is_load,
    output logic              ex_reg_write,
    output logic              id_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(cpu_pkg::REG_ZERO);

    logic              exFwdOk;
    logic              memWriting;
    logic              loadUse;
    logic [DATA_W-1:0] rAResolved;
    logic [DATA_W-1:0] rBResolved;

    // A load's EX result is an address, not data, so it is never forwarded from EX.
    assign exFwdOk    = ex_valid & ex_reg_write & ~ex_is_load;
    assign memWriting = mem_valid & mem_reg_write;

    operand_resolve #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_resolve_rA (
        .srcAddress   (id_rA_address),
        .idData       (id_rA_data),
        .forward      (forward_rA),
        .exFwdOk      (exFwdOk),
        .exResult     (ex_result),
        .memWriting   (memWriting),
        .memRdAddress (mem_rD_address),
        .memResult    (mem_result),
        .data         (rAResolved)
    );

    operand_resolve #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_resolve_rB (
        .srcAddress   (id_rB_address),
        .idData       (id_rB_data),
        .forward      (forward_rB),
        .exFwdOk      (exFwdOk),
        .exResult     (ex_result),
        .memWriting   (memWriting),
        .memRdAddress (mem_rD_address),
        .memResult    (mem_result),
        .data         (rBResolved)
    );

    assign loadUse = id_valid & ex_valid & ex_is_load & (ex_rD_address != ZERO) &
                     ((id_rA_address == ex_rD_address) | (id_rB_address == ex_rD_address));

    // A taken branch squashes the consumer, so its hazard must not hold IF/ID.
    assign id_stall = ex_hold | (loadUse & ~flush);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_rA_address <= '0;
            ex_rB_address <= '0;
            ex_rD_address <= '0;
            ex_rA_data    <= '0;
            ex_rB_data    <= '0;
            ex_opcode     <= '0;
            ex_func       <= '0;
            ex_is_load    <= 1'b0;
            ex_reg_write  <= 1'b0;
            bubble_count  <= '0;
        end else if (!ex_hold) begin
            if (flush) begin
                ex_valid      <= 1'b0;
                ex_rA_address <= '0;
                ex_rB_address <= '0;
                ex_rD_address <= '0;
                ex_rA_data    <= '0;
                ex_rB_data    <= '0;
                ex_opcode     <= '0;
                ex_func       <= '0;
                ex_is_load    <= 1'b0;
                ex_reg_write  <= 1'b0;
            end else if (loadUse) begin
                ex_valid     <= 1'b0;
                ex_is_load   <= 1'b0;
                ex_reg_write <= 1'b0;
                if (!(&bubble_count)) begin
                    bubble_count <= bubble_count + CNT_W'(1);
                end
            end else begin
                ex_valid      <= id_valid;
                ex_rA_address <= id_rA_address;
                ex_rB_address <= id_rB_address;
                ex_rD_address <= id_rD_address;
                ex_rA_data    <= rAResolved;
                ex_rB_data    <= rBResolved;
                ex_opcode     <= id_opcode;
                ex_func       <= id_func;
                ex_is_load    <= id_is_load;
                ex_reg_write  <= id_reg_write;
            end
        end
    end

endmodule
